// File: rtl/led_pio_pkg.sv
// Shared definitions for the LED PIO block: register addresses and the address type.
package led_pio_pkg;

    typedef logic [2:0] addr_t;

    localparam addr_t ADDR_DATA     = 3'd0;
    localparam addr_t ADDR_BLINK_EN = 3'd1;
    localparam addr_t ADDR_PERIOD   = 3'd2;
    localparam addr_t ADDR_STATUS   = 3'd3;
    localparam addr_t ADDR_OUTSET   = 3'd4;
    localparam addr_t ADDR_OUTCLR   = 3'd5;

endpackage

// File: rtl/led_pio_blink_timer.sv
// Blink phase generator: phase toggles every `period` cycles, holds 1 when period is 0.
module led_pio_blink_timer #(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_wr,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    // A PERIOD write restarts the half-period and wins over a coincident wrap.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (period_wr || period == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == period - PERIOD_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/led_pio_blink.sv
// Avalon-MM LED PIO with set/clear registers and optional per-channel blinking.
// Blink support (BLINK_EN, PERIOD, STATUS, timer) is built only when LED_PIO_BLINK_EN is defined.
module led_pio_blink
    import led_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      PERIOD_W    = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  addr_t            address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_q, data_d;
    logic             unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (address)
                ADDR_DATA:   data_d = wdata;
                ADDR_OUTSET: data_d = data_q | wdata;
                ADDR_OUTCLR: data_d = data_q & ~wdata;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) data_q <= RESET_VALUE;
        else          data_q <= data_d;
    end

`ifdef LED_PIO_BLINK_EN
    logic [WIDTH-1:0]    blink_en_q, blink_en_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_wr;
    logic                phase;

    assign period_wr = wr && (address == ADDR_PERIOD);

    always_comb begin
        blink_en_d = blink_en_q;
        period_d   = period_q;
        if (wr && address == ADDR_BLINK_EN) blink_en_d = wdata;
        if (period_wr)                      period_d   = writedata[PERIOD_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_en_q <= '0;
            period_q   <= '0;
        end else begin
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
        end
    end

    led_pio_blink_timer #(
        .PERIOD_W(PERIOD_W)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .period    (period_q),
        .period_wr (period_wr),
        .phase     (phase)
    );

    // Blinking channels are gated low during the off half of the phase.
    assign out_port = data_q & ~(blink_en_q & {WIDTH{~phase}});

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata = 32'(data_q);
            ADDR_BLINK_EN: readdata = 32'(blink_en_q);
            ADDR_PERIOD:   readdata = 32'(period_q);
            ADDR_STATUS:   readdata = {31'b0, phase};
            default:       ;
        endcase
    end
`else
    assign out_port = data_q;

    always_comb begin
        readdata = '0;
        if (address == ADDR_DATA) readdata = 32'(data_q);
    end
`endif

endmodule

// File: tb/tb_led_pio_blink.sv
// Self-checking bench for led_pio_blink against a cycle-count based reference model.
module tb_led_pio_blink;

    localparam int unsigned      W    = 10;
    localparam logic [W-1:0]     RV   = 10'h155;
    localparam int unsigned      PW   = 24;
`ifdef LED_PIO_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;

    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;

    // Reference model: phase derived from edges elapsed since the last PERIOD write or reset.
    logic [W-1:0]  m_data, m_ben;
    logic [PW-1:0] m_period;
    longint unsigned cyc = 0, t0 = 0;

    led_pio_blink #(
        .WIDTH       (W),
        .RESET_VALUE (RV),
        .PERIOD_W    (PW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    function automatic logic m_phase();
        longint unsigned q;
        if (m_period == '0) return 1'b1;
        q = (cyc - t0) / m_period;
        return (q % 2) == 0;
    endfunction

    function automatic longint unsigned m_cnt();
        if (m_period == '0) return 0;
        return (cyc - t0) % m_period;
    endfunction

    function automatic logic [W-1:0] m_out();
        return m_ben == '0 ? m_data : (m_phase() ? m_data : (m_data & ~m_ben));
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd1:    return BLINK ? 32'(m_ben) : 32'd0;
            3'd2:    return BLINK ? 32'(m_period) : 32'd0;
            3'd3:    return BLINK ? 32'(m_phase()) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_data   = RV;
        m_ben    = '0;
        m_period = '0;
        t0       = cyc;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One bus cycle: drive, clock, update model, then check out_port and a read at ra.
    task automatic bus(input bit cs, input bit wr, input logic [2:0] a,
                       input logic [31:0] d, input logic [2:0] ra);
        logic [W-1:0] wd;
        chipselect = cs;
        write_n    = ~wr;
        address    = a;
        writedata  = d;
        @(posedge clk);
        cyc++;
        wd = d[W-1:0];
        if (cs && wr) begin
            case (a)
                3'd0: m_data = wd;
                3'd1: if (BLINK) m_ben = wd;
                3'd2: if (BLINK) begin m_period = d[PW-1:0]; t0 = cyc; end
                3'd4: m_data = m_data | wd;
                3'd5: m_data = m_data & ~wd;
                default: ;
            endcase
        end
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = ra;
        #1;
        check("out_port", 32'(out_port), 32'(m_out()));
        check($sformatf("read@%0d", ra), readdata, m_read(ra));
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input logic [2:0] ra);
        bus(1'b1, 1'b1, a, d, ra);
    endtask

    task automatic idle(input int unsigned n, input logic [2:0] ra);
        for (int unsigned i = 0; i < n; i++) bus(1'b0, 1'b1, 3'd0, 32'h0, ra);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 32'(out_port), 32'(RV));
        for (int unsigned a = 1; a <= 3; a++) begin
            address = 3'(a);
            #1;
            check($sformatf("rst_read@%0d", a), readdata, (a == 3 && BLINK) ? 32'd1 : 32'd0);
        end
        reset_n = 1'b1;

        // Set/clear composition
        wr_reg(3'd0, 32'h00F, 3'd0);
        wr_reg(3'd4, 32'h300, 3'd0);
        wr_reg(3'd5, 32'h003, 3'd0);
        check("setclr_data", readdata, 32'h30C);
        check("setclr_out", 32'(out_port), 32'h30C);

        // Basic blink on channel 0
        wr_reg(3'd0, 32'h3FF, 3'd3);
        wr_reg(3'd1, 32'h001, 3'd3);
        wr_reg(3'd2, 32'd4, 3'd3);
        idle(20, 3'd3);

        // PERIOD rewrite exactly on the wrap cycle
        for (int unsigned i = 0; i < 20; i++) begin
            if (m_period != '0 && m_cnt() == m_period - 1) break;
            idle(1, 3'd3);
        end
        wr_reg(3'd2, 32'd3, 3'd3);
        idle(10, 3'd3);

        // PERIOD cleared while the phase is low
        for (int unsigned i = 0; i < 20; i++) begin
            if (!m_phase()) break;
            idle(1, 3'd3);
        end
        wr_reg(3'd2, 32'd0, 3'd3);
        idle(6, 3'd3);

        // Writes to STATUS and reserved addresses
        wr_reg(3'd3, 32'hFFFF_FFFF, 3'd0);
        wr_reg(3'd6, 32'hFFFF_FFFF, 3'd0);
        wr_reg(3'd7, 32'hFFFF_FFFF, 3'd1);

        // Asynchronous reset in the middle of blinking
        wr_reg(3'd1, 32'h3FF, 3'd3);
        wr_reg(3'd2, 32'd2, 3'd3);
        idle(3, 3'd3);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_out", 32'(out_port), 32'(RV));
        @(posedge clk);
        cyc++;
        t0 = cyc;
        #1;
        reset_n = 1'b1;
        idle(6, 3'd3);

        // Randomized traffic
        for (int unsigned i = 0; i < 400; i++) begin
            logic [2:0]  a, ra;
            logic [31:0] d;
            bit          cs, we;
            a  = 3'($urandom_range(0, 7));
            ra = 3'($urandom_range(0, 7));
            d  = (a == 3'd2) ? 32'($urandom_range(0, 5)) : $urandom;
            cs = ($urandom_range(0, 2) != 0);
            we = ($urandom_range(0, 3) == 0);
            bus(cs, we, a, d, ra);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
